eros_obi_timeout_bridge: RTL and testbench

EROS_OBI_TIMEOUT_BRIDGE -- requirements
Module: eros_obi_timeout_bridge

---
 rtl/eros_obi_pkg.sv | 18 +
 rtl/eros_pkg.sv | 16 +
 rtl/eros_obi_if.sv | 17 +
 rtl/eros_sat_counter.sv | 25 ++
 rtl/eros_obi_timeout_bridge.sv | 122 ++++++++++++
 tb/tb_eros_obi_timeout_bridge.sv | 257 +++++++++++++++++++++++++
 6 files changed

// File: rtl/eros_obi_pkg.sv
// OBI request/response bundles shared by the eros cluster and the SoC bus.
package eros_obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/eros_pkg.sv
// Cluster-level types and constants for the eros OBI timeout bridge.
package eros_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ERR,
        DRAIN
    } bridge_state_e;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hBADC_AB1E;

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned LATE_W = 8;

endpackage

// File: rtl/eros_obi_if.sv
// One OBI link: request from master, response from slave.
interface eros_obi_if;

    eros_obi_pkg::obi_req_t  req;
    eros_obi_pkg::obi_resp_t resp;

    modport master (
        output req,
        input  resp
    );

    modport slave (
        input  req,
        output resp
    );

endinterface

// File: rtl/eros_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module eros_sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;
    logic             w_full;

    assign w_full  = &r_count;
    assign o_count = r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_inc && !w_full) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/eros_obi_timeout_bridge.sv
// OBI bridge that answers with an error word when the downstream slave
// stays silent too long, then drains or abandons the stale transaction.
module eros_obi_timeout_bridge
    import eros_obi_pkg::*;
    import eros_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  obi_req_t          up_req_i,
    output obi_resp_t         up_resp_o,
    output obi_req_t          dn_req_o,
    input  obi_resp_t         dn_resp_i,
    output logic              timeout_o,
    input  logic              clear_i,
    output logic [LATE_W-1:0] late_cnt_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    bridge_state_e    r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;

    logic w_grant;
    logic w_at_limit;
    logic w_idle_view;
    logic w_late;

    assign w_grant     = up_req_i.req && dn_resp_i.gnt;
    assign w_at_limit  = (r_cnt == LIMIT);
    assign w_idle_view = rst_i || (r_state == IDLE);
    assign timeout_o   = r_timeout;

    // Any rvalid not owned by an open WAIT is a dropped response.
    assign w_late = dn_resp_i.rvalid && !rst_i && (r_state != WAIT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == ERR) begin
                r_timeout <= 1'b1;
            end else if (clear_i) begin
                r_timeout <= 1'b0;
            end

            unique case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_state <= WAIT;
                        r_cnt   <= '0;
                    end
                end
                WAIT: begin
                    if (dn_resp_i.rvalid) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (w_at_limit) begin
                        r_state <= ERR;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ERR: begin
                    r_state <= DRAIN;
                    r_cnt   <= '0;
                end
                DRAIN: begin
                    if (dn_resp_i.rvalid || w_at_limit) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        dn_req_o         = up_req_i;
        up_resp_o.gnt    = 1'b0;
        up_resp_o.rvalid = 1'b0;
        up_resp_o.rdata  = dn_resp_i.rdata;
        if (w_idle_view) begin
            up_resp_o.gnt = dn_resp_i.gnt;
        end else begin
            dn_req_o.req = 1'b0;
            unique case (r_state)
                WAIT: begin
                    up_resp_o.rvalid = dn_resp_i.rvalid;
                end
                ERR: begin
                    up_resp_o.rvalid = 1'b1;
                    up_resp_o.rdata  = ERR_RDATA;
                end
                default: begin
                    up_resp_o.rvalid = 1'b0;
                end
            endcase
        end
    end

    eros_sat_counter #(
        .WIDTH (LATE_W)
    ) u_late_cnt (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_inc   (w_late),
        .o_count (late_cnt_o)
    );

endmodule

// File: tb/tb_eros_obi_timeout_bridge.sv
// Bench for eros_obi_timeout_bridge: directed scenarios plus random traffic
// against an age-since-grant model of the bridge.
module tb_eros_obi_timeout_bridge;
    import eros_obi_pkg::*;

    localparam int T = 8;
    localparam logic [31:0] ERR_WORD = 32'hBADCAB1E;

    logic       clk;
    logic       rst;
    logic       clear;
    logic       timeout_o;
    logic [7:0] late_cnt_o;

    eros_obi_if up_if ();
    eros_obi_if dn_if ();

    eros_obi_timeout_bridge #(
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .up_req_i   (up_if.req),
        .up_resp_o  (up_if.resp),
        .dn_req_o   (dn_if.req),
        .dn_resp_i  (dn_if.resp),
        .timeout_o  (timeout_o),
        .clear_i    (clear),
        .late_cnt_o (late_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: m_age counts cycles since the grant cycle (grant = age 0).
    bit m_busy;
    int m_age;
    int m_late;
    bit m_to;

    logic        obs_gnt;
    logic        obs_rv;
    logic [31:0] obs_rd;
    logic [31:0] obs_daddr;

    task automatic check(input string tag,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic cyc(input bit r, input logic [31:0] a,
                       input bit g, input bit v,
                       input logic [31:0] d,
                       input bit c, input bit rs);
        bit          e_gnt;
        bit          e_rv;
        bit          e_dreq;
        logic [31:0] e_rd;
        up_if.req  = '{req: r, we: 1'b0, be: 4'hF,
                       addr: a, wdata: 32'h0};
        dn_if.resp = '{gnt: g, rvalid: v, rdata: d};
        clear = c;
        rst   = rs;
        #2;
        e_rd = d;
        if (rs || !m_busy) begin
            e_gnt  = g;
            e_rv   = 1'b0;
            e_dreq = r;
        end else begin
            e_gnt  = 1'b0;
            e_dreq = 1'b0;
            if (m_age <= T) begin
                e_rv = v;
            end else if (m_age == T + 1) begin
                e_rv = 1'b1;
                e_rd = ERR_WORD;
            end else begin
                e_rv = 1'b0;
            end
        end
        obs_gnt   = up_if.resp.gnt;
        obs_rv    = up_if.resp.rvalid;
        obs_rd    = up_if.resp.rdata;
        obs_daddr = dn_if.req.addr;
        check("up_gnt", 32'(obs_gnt), 32'(e_gnt));
        check("up_rvalid", 32'(obs_rv), 32'(e_rv));
        if (e_rv) check("up_rdata", obs_rd, e_rd);
        check("dn_req", 32'(dn_if.req.req), 32'(e_dreq));
        check("dn_addr", obs_daddr, a);
        check("timeout", 32'(timeout_o), 32'(m_to));
        check("late_cnt", 32'(late_cnt_o), 32'(m_late));
        @(posedge clk);
        if (rs) begin
            m_busy = 1'b0;
            m_late = 0;
            m_to   = 1'b0;
        end else begin
            if (v && (!m_busy || m_age > T) && m_late < 255)
                m_late++;
            if (m_busy && m_age == T + 1) m_to = 1'b1;
            else if (c) m_to = 1'b0;
            if (!m_busy) begin
                if (r && g) begin
                    m_busy = 1'b1;
                    m_age  = 1;
                end
            end else if (v && m_age != T + 1) begin
                m_busy = 1'b0;
            end else if (m_age == 2 * T + 1) begin
                m_busy = 1'b0;
            end else begin
                m_age++;
            end
        end
        #1;
    endtask

    task automatic idle();
        cyc(0, 32'h0, 0, 0, 32'h0, 0, 0);
    endtask

    task automatic grant(input logic [31:0] a);
        cyc(1, a, 1, 0, 32'h0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        up_if.req  = '0;
        dn_if.resp = '0;
        clear  = 1'b0;
        rst    = 1'b1;
        m_busy = 1'b0;
        m_age  = 0;
        m_late = 0;
        m_to   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_timeout", 32'(timeout_o), 32'd0);
        check("rst_late", 32'(late_cnt_o), 32'd0);
        check("rst_rvalid", 32'(up_if.resp.rvalid), 32'd0);
        cyc(1, 32'h44, 0, 0, 32'h0, 0, 1);
        check("rst_dn_follow", 32'(dn_if.req.req), 32'd1);

        // Normal read, response three cycles after grant.
        grant(32'h1000);
        check("t33_dn_addr", obs_daddr, 32'h1000);
        check("t33_gnt", 32'(obs_gnt), 32'd1);
        idle();
        idle();
        check("t33_no_early_rv", 32'(obs_rv), 32'd0);
        cyc(0, 32'h0, 0, 1, 32'h12345678, 0, 0);
        check("t33_rv", 32'(obs_rv), 32'd1);
        check("t33_rd", obs_rd, 32'h12345678);
        check("t33_timeout", 32'(timeout_o), 32'd0);

        // Silent slave: error word in the 9th cycle, grants blocked in drain.
        grant(32'h2000);
        for (int i = 1; i <= T; i++) begin
            idle();
            check("t34_wait_rv", 32'(obs_rv), 32'd0);
        end
        idle();
        check("t34_err_rv", 32'(obs_rv), 32'd1);
        check("t34_err_rd", obs_rd, ERR_WORD);
        check("t34_timeout", 32'(timeout_o), 32'd1);
        for (int i = 0; i < T; i++) begin
            grant(32'h3000);
            check("t34_drain_gnt", 32'(obs_gnt), 32'd0);
        end
        grant(32'h3000);
        check("t34_regrant", 32'(obs_gnt), 32'd1);
        cyc(0, 32'h0, 0, 1, 32'h33333333, 0, 0);
        check("t34_rv2", 32'(obs_rv), 32'd1);

        // Response at the last possible wait cycle beats the timeout.
        cyc(0, 32'h0, 0, 0, 32'h0, 1, 0);
        check("t35_cleared", 32'(timeout_o), 32'd0);
        grant(32'h4000);
        for (int i = 1; i < T; i++) idle();
        cyc(0, 32'h0, 0, 1, 32'hCAFE0008, 0, 0);
        check("t35_rv", 32'(obs_rv), 32'd1);
        check("t35_rd", obs_rd, 32'hCAFE0008);
        check("t35_timeout", 32'(timeout_o), 32'd0);

        // Late response during drain is swallowed and counted.
        grant(32'h5000);
        for (int i = 1; i <= T; i++) idle();
        idle();
        check("t36_err_rv", 32'(obs_rv), 32'd1);
        idle();
        idle();
        cyc(0, 32'h0, 0, 1, 32'hDEAD0001, 0, 0);
        check("t36_late_rv", 32'(obs_rv), 32'd0);
        check("t36_late_cnt", 32'(late_cnt_o), 32'd1);
        grant(32'h5004);
        check("t36_idle_gnt", 32'(obs_gnt), 32'd1);
        cyc(0, 32'h0, 0, 1, 32'h5004, 0, 0);

        // Clear colliding with a timeout set loses; lone clear wins.
        grant(32'h6000);
        for (int i = 1; i <= T; i++) idle();
        cyc(0, 32'h0, 0, 0, 32'h0, 1, 0);
        check("t37_set_wins", 32'(timeout_o), 32'd1);
        cyc(0, 32'h0, 0, 0, 32'h0, 1, 0);
        check("t37_clear", 32'(timeout_o), 32'd0);
        for (int i = 1; i < T; i++) idle();

        // Reset mid-wait abandons silently.
        grant(32'h7000);
        for (int i = 0; i < 3; i++) idle();
        cyc(0, 32'h0, 0, 0, 32'h0, 0, 1);
        check("t38_rst_rv", 32'(obs_rv), 32'd0);
        check("t38_late0", 32'(late_cnt_o), 32'd0);
        check("t38_to0", 32'(timeout_o), 32'd0);
        for (int i = 0; i < 2 * T + 2; i++) begin
            idle();
            check("t38_no_err", 32'(obs_rv), 32'd0);
        end
        cyc(0, 32'h0, 0, 1, 32'h7777, 0, 0);
        check("t38_spurious", 32'(late_cnt_o), 32'd1);

        // Late counter saturates.
        for (int i = 0; i < 258; i++)
            cyc(0, 32'h0, 0, 1, 32'h0, 0, 0);
        check("sat_late", 32'(late_cnt_o), 32'd255);

        cyc(0, 32'h0, 0, 0, 32'h0, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 1) == 1),
                $urandom,
                ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 9) == 0),
                $urandom,
                ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 99) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
